game_flow_ctrl: RTL and testbench
=================================

// Module: game_flow_ctrl
// PURPOSE
//  Round sequencer for the Tom & Jerry game. Consumes the key-decoder pulses, the
//  cheese-taken pulse and the Tom/Jerry overlap flag. Owns the game state, cheese score,
//  round timer and win/lose result. Drives the freeze gate for both move controllers,
//  the re-placement request for the cheese position generator, and the result code
//  for the game-over overlay.
// PARAMETERS
//  CLK_HZ          40_000_000  pixel/system clock frequency, sets the 1 s prescaler
//  ROUND_SEC       60          round length in seconds (1..255)
//  WIN_CHEESE      10          cheese count that wins the round (1..255)
//  COLLIDE_FRAMES  3           consecutive overlapping frames that end the round (1..15)
// PORTS
//  clk            in   1  system clock, all logic on posedge
//  rst            in   1  synchronous reset, active-low
//  start          in   1  1-cycle pulse, start round from IDLE
//  restart        in   1  1-cycle pulse, abort/restart round from any state
//  cheese_taken   in   1  1-cycle pulse, Jerry collected cheese
//  overlap        in   1  level, Tom and Jerry bounding boxes intersect
//  vsync          in   1  VGA vsync from timing chain; rising edge = frame tick
//  pause_key      in   1  1-cycle pulse; used only with GAME_PAUSE_EN
//  state          out  3  game_pkg::state_t, current state
//  freeze         out  1  1 = move controllers hold position
//  cheese_req     out  1  1-cycle pulse, request new random cheese position
//  cheese_ctr     out  8  cheese collected this round
//  sec_left       out  8  seconds remaining
//  gameover       out  2  00 none, 01 Jerry wins, 10 Tom wins
// BEHAVIOUR
//  - All outputs registered. Each output changes 1 cycle after the causing input edge.
//  - Reset (rst==0 at posedge): state=IDLE, freeze=1, cheese_req=0, cheese_ctr=0,
//    sec_left=ROUND_SEC, gameover=00. Prescaler, frame-edge register and overlap
//    counter also clear. Reset wins over every input, including mid-round.
//  - Reload: cheese_ctr=0, sec_left=ROUND_SEC, prescaler=0, overlap count=0,
//    cheese_req=1 for 1 cycle.
//  - Priority per cycle: restart > win > lose > other events.
//  - IDLE: freeze=1, timer held. start -> PLAY with reload.
//  - PLAY: freeze=0.
//    - cheese_taken: cheese_ctr+1, saturating at 255; cheese_req pulses the next cycle.
//      If the new count == WIN_CHEESE: -> WIN, gameover=01, no cheese_req.
//    - Frame tick (vsync 0->1, registered edge detect):
//      - overlap=1: overlap count +1, saturating.
//      - overlap=0: overlap count = 0.
//      - Count reaching COLLIDE_FRAMES: -> LOSE, gameover=10.
//    - Second tick (prescaler wraps at CLK_HZ-1): sec_left-1. The 1->0 transition
//      -> LOSE, gameover=10. sec_left never wraps below 0.
//    - Same-cycle win and lose: WIN.
//  - WIN / LOSE: freeze=1, counters held, gameover held. start is ignored.
//  - restart (any state, incl. IDLE): -> PLAY with reload, gameover=00.
// CONFIGURATION
//  - GAME_PAUSE_EN defined:
//    - Adds state PAUSE.
//    - In PLAY, pause_key -> PAUSE (freeze=1; prescaler, timer and overlap count held;
//      cheese_taken ignored).
//    - In PAUSE, pause_key -> PLAY, resuming the prescaler count exactly.
//    - restart still overrides.
//  - Not defined: pause_key is unused, PAUSE is unreachable, state never encodes it.
// STRUCTURE
//  - game_pkg: state_t enum {IDLE, PLAY, WIN, LOSE, PAUSE}; GO_NONE/GO_JERRY/GO_TOM
//    2-bit constants. Shared with draw_gameover and the move controllers.
//  - Sub-module sec_tick_gen (#CLK_HZ): clk, rst, run, clr -> tick.
//    Counter wraps at CLK_HZ-1; tick is 1-cycle.
//  - FSM, counters and vsync edge detect stay in this module.
// TESTING (bench params: CLK_HZ=10, ROUND_SEC=3, WIN_CHEESE=2, COLLIDE_FRAMES=2)
//  1. Reset, then start -> next cycle state=PLAY, freeze=0, cheese_req=1 for 1 cycle,
//     sec_left=3.
//  2. Two cheese_taken pulses -> cheese_ctr=1 with cheese_req; then cheese_ctr=2,
//     state=WIN, gameover=01, freeze=1.
//  3. overlap=1 across 2 vsync rises -> LOSE, gameover=10. A single-frame overlap
//     followed by overlap=0 -> stays PLAY.
//  4. Idle in PLAY for 30 clk -> sec_left 2,1,0 on every 10th clk; LOSE at 0.
//     No further decrement afterwards.
//  5. Final cheese and second overlap frame in same cycle -> WIN. restart in LOSE ->
//     PLAY, cheese_ctr=0, sec_left=3, gameover=00.
//  6. rst=0 mid-PLAY for 1 cycle -> all outputs equal reset values the next cycle.
//     With GAME_PAUSE_EN, pause_key holds sec_left for 50 clk, then resumes exactly.

Source files
------------

// File: rtl/game_flow_ctrl_pkg.sv
// game_pkg: shared types for the Tom & Jerry game.
// Shared by game_flow_ctrl, draw_gameover and the move controllers.
//   state_t   - round state. PAUSE exists only when GAME_PAUSE_EN is defined.
//   GO_*      - 2-bit game-over result codes.
//   sat_inc8  - saturating 8-bit increment.
package game_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PLAY  = 3'd1,
    WIN   = 3'd2,
    LOSE  = 3'd3,
    PAUSE = 3'd4
  } state_t;

  localparam logic [1:0] GO_NONE  = 2'b00;
  localparam logic [1:0] GO_JERRY = 2'b01;
  localparam logic [1:0] GO_TOM   = 2'b10;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/game_flow_ctrl_if.sv
// game_flow_ctrl_if: game-flow signal bundle.
//   Inputs to the sequencer:
//     start, restart, cheese_taken, pause_key (pulses), overlap, vsync (levels).
//   Outputs from the sequencer:
//     state, freeze, cheese_req, cheese_ctr, sec_left, gameover.
//   master - drives the inputs and observes the results (key decoder, game logic, bench).
//   slave  - the sequencer itself.
interface game_flow_ctrl_if;
  import game_pkg::*;

  logic       start;
  logic       restart;
  logic       cheese_taken;
  logic       overlap;
  logic       vsync;
  logic       pause_key;
  state_t     state;
  logic       freeze;
  logic       cheese_req;
  logic [7:0] cheese_ctr;
  logic [7:0] sec_left;
  logic [1:0] gameover;

  modport master (
    output start, restart, cheese_taken, overlap, vsync, pause_key,
    input  state, freeze, cheese_req, cheese_ctr, sec_left, gameover
  );

  modport slave (
    input  start, restart, cheese_taken, overlap, vsync, pause_key,
    output state, freeze, cheese_req, cheese_ctr, sec_left, gameover
  );

endinterface

// File: rtl/game_flow_ctrl_sec_tick_gen.sv
// sec_tick_gen: one-second prescaler.
//   clk  - system clock
//   rst  - synchronous reset, active-low
//   run  - count enable; the count is held while low
//   clr  - return the count to 0 (wins over run)
//   tick - 1-cycle pulse in the cycle the count wraps from CLK_HZ-1 to 0
module sec_tick_gen #(
  parameter int unsigned CLK_HZ = 40_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int unsigned     CntW   = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_HZ - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = run && !clr && (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: round sequencer for the Tom & Jerry game.
// Owns game state, cheese score, round timer and the win/lose result.
//   clk - system clock
//   rst - synchronous reset, active-low
//   bus - game_flow_ctrl_if.slave
//     in : start, restart, cheese_taken, pause_key (pulses), overlap, vsync (levels)
//     out: state, freeze, cheese_req, cheese_ctr, sec_left, gameover (all registered)
// Optional build macro: GAME_PAUSE_EN adds the PAUSE state, toggled by pause_key.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 40_000_000,
  parameter int unsigned ROUND_SEC      = 60,
  parameter int unsigned WIN_CHEESE     = 10,
  parameter int unsigned COLLIDE_FRAMES = 3
) (
  input logic            clk,
  input logic            rst,
  game_flow_ctrl_if.slave bus
);

  state_t     state_q, state_d;
  logic       freeze_q, freeze_d;
  logic       cheese_req_q, cheese_req_d;
  logic [7:0] cheese_ctr_q, cheese_ctr_d;
  logic [7:0] sec_left_q, sec_left_d;
  logic [1:0] gameover_q, gameover_d;
  logic [3:0] ovl_cnt_q, ovl_cnt_d;
  logic       vsync_q;

  logic frame_tick, sec_tick;
  logic reload, win, lose, cheese_ev;

  assign frame_tick = bus.vsync && !vsync_q;

`ifndef GAME_PAUSE_EN
  logic unused_pause_key;
  assign unused_pause_key = bus.pause_key;
`endif

  // Prescaler only runs in PLAY, so IDLE/WIN/LOSE/PAUSE all hold its count.
  sec_tick_gen #(
    .CLK_HZ(CLK_HZ)
  ) u_sec_tick_gen (
    .clk (clk),
    .rst (rst),
    .run (state_q == PLAY),
    .clr (reload),
    .tick(sec_tick)
  );

  // State register (together with the counters and output registers).
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      freeze_q     <= 1'b1;
      cheese_req_q <= 1'b0;
      cheese_ctr_q <= '0;
      sec_left_q   <= 8'(ROUND_SEC);
      gameover_q   <= GO_NONE;
      ovl_cnt_q    <= '0;
      vsync_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      freeze_q     <= freeze_d;
      cheese_req_q <= cheese_req_d;
      cheese_ctr_q <= cheese_ctr_d;
      sec_left_q   <= sec_left_d;
      gameover_q   <= gameover_d;
      ovl_cnt_q    <= ovl_cnt_d;
      vsync_q      <= bus.vsync;
    end
  end

  // Next state and counters.
  always_comb begin
    state_d      = state_q;
    cheese_ctr_d = cheese_ctr_q;
    sec_left_d   = sec_left_q;
    ovl_cnt_d    = ovl_cnt_q;
    reload       = 1'b0;
    win          = 1'b0;
    lose         = 1'b0;
    cheese_ev    = 1'b0;

    if (bus.restart) begin
      reload  = 1'b1;
      state_d = PLAY;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            reload  = 1'b1;
            state_d = PLAY;
          end
        end
        PLAY: begin
          if (bus.cheese_taken) begin
            cheese_ctr_d = sat_inc8(cheese_ctr_q);
            if (cheese_ctr_d == 8'(WIN_CHEESE)) begin
              win = 1'b1;
            end else begin
              cheese_ev = 1'b1;
            end
          end
          if (frame_tick) begin
            if (bus.overlap) begin
              ovl_cnt_d = (ovl_cnt_q == 4'hf) ? ovl_cnt_q : ovl_cnt_q + 4'd1;
            end else begin
              ovl_cnt_d = '0;
            end
            if (ovl_cnt_d >= 4'(COLLIDE_FRAMES)) begin
              lose = 1'b1;
            end
          end
          if (sec_tick && (sec_left_q != 8'd0)) begin
            sec_left_d = sec_left_q - 8'd1;
            if (sec_left_q == 8'd1) begin
              lose = 1'b1;
            end
          end
          if (win) begin
            state_d = WIN;
          end else if (lose) begin
            state_d = LOSE;
          end
`ifdef GAME_PAUSE_EN
          else if (bus.pause_key) begin
            state_d = PAUSE;
          end
`endif
        end
`ifdef GAME_PAUSE_EN
        PAUSE: begin
          if (bus.pause_key) begin
            state_d = PLAY;
          end
        end
`endif
        default: ;
      endcase
    end

    if (reload) begin
      cheese_ctr_d = '0;
      sec_left_d   = 8'(ROUND_SEC);
      ovl_cnt_d    = '0;
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    freeze_d     = (state_d != PLAY);
    // A losing cycle ends the round, so no replacement cheese is requested.
    cheese_req_d = reload || (cheese_ev && !lose);
    gameover_d   = gameover_q;
    if (reload) begin
      gameover_d = GO_NONE;
    end else if (win) begin
      gameover_d = GO_JERRY;
    end else if (lose) begin
      gameover_d = GO_TOM;
    end
  end

  assign bus.state      = state_q;
  assign bus.freeze     = freeze_q;
  assign bus.cheese_req = cheese_req_q;
  assign bus.cheese_ctr = cheese_ctr_q;
  assign bus.sec_left   = sec_left_q;
  assign bus.gameover   = gameover_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl with CLK_HZ=10, ROUND_SEC=3, WIN_CHEESE=2, COLLIDE_FRAMES=2.
// Expected outputs are queued as each cycle's stimulus is driven and popped/compared
// 1 time unit after the following posedge.
module tb_game_flow_ctrl;
  import game_pkg::*;

  logic clk = 1'b0;
  logic rst;

  game_flow_ctrl_if bus ();

  game_flow_ctrl #(
    .CLK_HZ        (10),
    .ROUND_SEC     (3),
    .WIN_CHEESE    (2),
    .COLLIDE_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    state_t     st;
    logic       frz;
    logic       req;
    logic [7:0] cc;
    logic [7:0] sl;
    logic [1:0] go;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input string tag, input state_t st, input logic frz,
                              input logic req, input logic [7:0] cc, input logic [7:0] sl,
                              input logic [1:0] go);
    exp_t e;
    e.tag = tag; e.st = st; e.frz = frz; e.req = req; e.cc = cc; e.sl = sl; e.go = go;
    return e;
  endfunction

  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb_q.pop_front();
      check({e.tag, ".state"}, 32'(bus.state), 32'(e.st));
      check({e.tag, ".freeze"}, 32'(bus.freeze), 32'(e.frz));
      check({e.tag, ".cheese_req"}, 32'(bus.cheese_req), 32'(e.req));
      check({e.tag, ".cheese_ctr"}, 32'(bus.cheese_ctr), 32'(e.cc));
      check({e.tag, ".sec_left"}, 32'(bus.sec_left), 32'(e.sl));
      check({e.tag, ".gameover"}, 32'(bus.gameover), 32'(e.go));
    end
  endtask

  // One clock: pulses asserted for exactly this cycle, levels (rst/overlap/vsync) as set.
  task automatic cyc(input logic st, input logic rs, input logic ch, input logic pk,
                     input exp_t e);
    @(negedge clk);
    bus.start        = st;
    bus.restart      = rs;
    bus.cheese_taken = ch;
    bus.pause_key    = pk;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    compare_out();
    bus.start        = 1'b0;
    bus.restart      = 1'b0;
    bus.cheese_taken = 1'b0;
    bus.pause_key    = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst              = 1'b0;
    bus.start        = 1'b0;
    bus.restart      = 1'b0;
    bus.cheese_taken = 1'b0;
    bus.overlap      = 1'b0;
    bus.vsync        = 1'b0;
    bus.pause_key    = 1'b0;

    // Reset state, with start asserted to show reset wins.
    cyc(1, 0, 0, 0, mk("rst0", IDLE, 1, 0, 0, 3, GO_NONE));
    cyc(0, 0, 0, 0, mk("rst1", IDLE, 1, 0, 0, 3, GO_NONE));
    rst = 1'b1;
    cyc(0, 0, 1, 0, mk("idle_cheese", IDLE, 1, 0, 0, 3, GO_NONE));

    // Start and cheese win.
    cyc(1, 0, 0, 0, mk("start", PLAY, 0, 1, 0, 3, GO_NONE));
    cyc(0, 0, 0, 0, mk("start_req_off", PLAY, 0, 0, 0, 3, GO_NONE));
    cyc(0, 0, 1, 0, mk("cheese1", PLAY, 0, 1, 1, 3, GO_NONE));
    cyc(0, 0, 1, 0, mk("cheese2_win", WIN, 1, 0, 2, 3, GO_JERRY));
    cyc(1, 0, 0, 0, mk("win_start_ign", WIN, 1, 0, 2, 3, GO_JERRY));
    cyc(0, 0, 1, 0, mk("win_held", WIN, 1, 0, 2, 3, GO_JERRY));

    // Two overlapping frames lose.
    cyc(0, 1, 0, 0, mk("restart_win", PLAY, 0, 1, 0, 3, GO_NONE));
    bus.overlap = 1'b1; bus.vsync = 1'b1;
    cyc(0, 0, 0, 0, mk("ovl_f1", PLAY, 0, 0, 0, 3, GO_NONE));
    bus.vsync = 1'b0;
    cyc(0, 0, 0, 0, mk("ovl_low", PLAY, 0, 0, 0, 3, GO_NONE));
    bus.vsync = 1'b1;
    cyc(0, 0, 0, 0, mk("ovl_f2_lose", LOSE, 1, 0, 0, 3, GO_TOM));

    // Interrupted overlap must not accumulate.
    cyc(0, 1, 0, 0, mk("restart_lose", PLAY, 0, 1, 0, 3, GO_NONE));
    bus.vsync = 1'b0;
    cyc(0, 0, 0, 0, mk("int_v0", PLAY, 0, 0, 0, 3, GO_NONE));
    bus.vsync = 1'b1;
    cyc(0, 0, 0, 0, mk("int_f1", PLAY, 0, 0, 0, 3, GO_NONE));
    bus.vsync = 1'b0; bus.overlap = 1'b0;
    cyc(0, 0, 0, 0, mk("int_v0b", PLAY, 0, 0, 0, 3, GO_NONE));
    bus.vsync = 1'b1;
    cyc(0, 0, 0, 0, mk("int_clear", PLAY, 0, 0, 0, 3, GO_NONE));
    bus.vsync = 1'b0; bus.overlap = 1'b1;
    cyc(0, 0, 0, 0, mk("int_v0c", PLAY, 0, 0, 0, 3, GO_NONE));
    bus.vsync = 1'b1;
    cyc(0, 0, 0, 0, mk("int_f1_again", PLAY, 0, 0, 0, 3, GO_NONE));
    bus.vsync = 1'b0; bus.overlap = 1'b0;

    // Round timer runs out.
    cyc(0, 1, 0, 0, mk("restart_timer", PLAY, 0, 1, 0, 3, GO_NONE));
    for (int i = 1; i <= 30; i++) begin
      logic [7:0] sl;
      sl = 8'(3 - i / 10);
      if (i == 30) cyc(0, 0, 0, 0, mk($sformatf("timer%0d", i), LOSE, 1, 0, 0, sl, GO_TOM));
      else cyc(0, 0, 0, 0, mk($sformatf("timer%0d", i), PLAY, 0, 0, 0, sl, GO_NONE));
    end
    for (int i = 0; i < 12; i++) begin
      cyc(0, 0, 0, 0, mk("timer_held", LOSE, 1, 0, 0, 0, GO_TOM));
    end

    // Same-cycle win and lose resolves to WIN.
    cyc(0, 1, 0, 0, mk("restart_from_lose", PLAY, 0, 1, 0, 3, GO_NONE));
    cyc(0, 0, 1, 0, mk("tie_cheese1", PLAY, 0, 1, 1, 3, GO_NONE));
    bus.overlap = 1'b1; bus.vsync = 1'b1;
    cyc(0, 0, 0, 0, mk("tie_f1", PLAY, 0, 0, 1, 3, GO_NONE));
    bus.vsync = 1'b0;
    cyc(0, 0, 0, 0, mk("tie_v0", PLAY, 0, 0, 1, 3, GO_NONE));
    bus.vsync = 1'b1;
    cyc(0, 0, 1, 0, mk("tie_win", WIN, 1, 0, 2, 3, GO_JERRY));
    bus.vsync = 1'b0; bus.overlap = 1'b0;

    // Reset mid-round, then restart works from IDLE.
    cyc(0, 1, 0, 0, mk("restart_pre_rst", PLAY, 0, 1, 0, 3, GO_NONE));
    cyc(0, 0, 1, 0, mk("pre_rst_cheese", PLAY, 0, 1, 1, 3, GO_NONE));
    rst = 1'b0;
    cyc(0, 0, 1, 0, mk("mid_rst", IDLE, 1, 0, 0, 3, GO_NONE));
    rst = 1'b1;
    cyc(0, 1, 0, 0, mk("restart_idle", PLAY, 0, 1, 0, 3, GO_NONE));

`ifdef GAME_PAUSE_EN
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0, mk("pre_pause", PLAY, 0, 0, 0, 3, GO_NONE));
    end
    cyc(0, 0, 0, 1, mk("pause", PAUSE, 1, 0, 0, 3, GO_NONE));
    for (int i = 0; i < 50; i++) begin
      cyc(0, 0, (i == 7), 0, mk("paused", PAUSE, 1, 0, 0, 3, GO_NONE));
    end
    cyc(0, 0, 0, 1, mk("resume", PLAY, 0, 0, 0, 3, GO_NONE));
    for (int j = 1; j <= 5; j++) begin
      cyc(0, 0, 0, 0, mk($sformatf("resume%0d", j), PLAY, 0, 0, 0, (j == 5) ? 8'd2 : 8'd3,
                         GO_NONE));
    end
`else
    // pause_key has no effect; prescaler keeps counting to the tick 10 cycles after restart.
    cyc(0, 0, 0, 1, mk("pause_ignored", PLAY, 0, 0, 0, 3, GO_NONE));
    for (int j = 2; j <= 10; j++) begin
      cyc(0, 0, 0, (j == 5), mk($sformatf("nopause%0d", j), PLAY, 0, 0, 0,
                                (j == 10) ? 8'd2 : 8'd3, GO_NONE));
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
